// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the elastic pipeline stage register.
//   - pipe_state_e   : occupancy state of the 2-entry stage (EMPTY/ONE/TWO)
//   - IF_ID_DATA_W   : default payload width for the IF/ID boundary {PC, Instr}
//   - ID_EX_DATA_W   : default payload width for the ID/EX boundary
//   - ARM_NOP        : canonical ARM no-op encoding (MOV r0, r0)
//   - if_id_payload(): packs a PC / instruction pair into an IF/ID payload
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Occupancy of the stage: EMPTY = no entry, ONE = main only, TWO = main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // {PC[31:0], Instruction[31:0]}
    localparam int unsigned IF_ID_DATA_W = 64;
    // {PC, Rn value, Rm value, Instruction}
    localparam int unsigned ID_EX_DATA_W = 128;

    // MOV r0, r0 (condition AL): architectural no-op.
    localparam logic [31:0] ARM_NOP = 32'hE1A0_0000;

    // A NOP-carrying IF/ID bubble, for instances that prefer a real NOP over zeros.
    localparam logic [IF_ID_DATA_W-1:0] IF_ID_NOP_BUBBLE = {32'h0, ARM_NOP};

    function automatic logic [IF_ID_DATA_W-1:0] if_id_payload(
        input logic [31:0] pc,
        input logic [31:0] instr
    );
        return {pc, instr};
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_sat_counter
// Saturating up-counter used for the stage's optional performance counters.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-low (clears the count)
//   i_inc    in   increment request for this cycle
//   o_count  out  current count; sticks at all-ones once reached
// -----------------------------------------------------------------------------
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        if (i_inc && (r_count != CNT_MAX)) begin
            w_count_nxt = r_count + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Elastic pipeline register carrying an opaque DATA_W payload between two
// pipeline stages with a valid/ready handshake. A main entry plus a skid entry
// let in_ready depend only on registered state (and freeze), so the upstream
// ready path never sees out_ready combinationally. Freeze stalls both sides;
// flush kills every held and incoming entry and refills with BUBBLE.
//
// Optional feature (macro PIPE_STAGE_PERF_CNT_EN): adds parameter CNT_W and the
// saturating performance counters stall_cnt / flush_cnt.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   freeze     in   stall: no accept and no issue this cycle
//   flush      in   synchronous kill of all held and incoming entries
//   in_valid   in   upstream payload valid
//   in_data    in   upstream payload
//   in_ready   out  stage can accept (from registered state, masked by freeze)
//   out_valid  out  downstream payload valid
//   out_data   out  downstream payload (BUBBLE when empty)
//   out_ready  in   downstream accepts
//   stall_cnt  out  [macro] cycles a valid entry was held back
//   flush_cnt  out  [macro] flush cycles that killed at least one valid entry
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W = IF_ID_DATA_W,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    parameter int unsigned       CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [DATA_W-1:0] r_skid_data;
    logic [DATA_W-1:0] w_skid_data_nxt;

    logic w_main_valid;
    logic w_skid_valid;
    logic w_accept;
    logic w_issue;

    // Entry validity is implied by the occupancy state; a skid entry only
    // exists while the main entry is also occupied.
    assign w_main_valid = (r_state == ONE) || (r_state == TWO);
    assign w_skid_valid = (r_state == TWO);

    assign in_ready  = ~w_skid_valid & ~freeze;
    assign out_valid = w_main_valid & ~freeze;
    assign out_data  = r_main_data;

    // Both handshakes already include ~freeze through in_ready / out_valid.
    assign w_accept = in_valid & in_ready;
    assign w_issue  = out_valid & out_ready;

    // Next-state and data-path steering.
    always_comb begin
        w_state_nxt     = r_state;
        w_main_data_nxt = r_main_data;
        w_skid_data_nxt = r_skid_data;

        if (flush) begin
            // Flush outranks freeze and drops the input presented this cycle.
            w_state_nxt     = EMPTY;
            w_main_data_nxt = BUBBLE;
            w_skid_data_nxt = BUBBLE;
        end else if (!freeze) begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt     = ONE;
                        w_main_data_nxt = in_data;
                    end
                end
                ONE: begin
                    if (w_accept && w_issue) begin
                        w_main_data_nxt = in_data;
                    end else if (w_accept) begin
                        w_state_nxt     = TWO;
                        w_skid_data_nxt = in_data;
                    end else if (w_issue) begin
                        w_state_nxt     = EMPTY;
                        w_main_data_nxt = BUBBLE;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain path exists.
                    if (w_issue) begin
                        w_state_nxt     = ONE;
                        w_main_data_nxt = r_skid_data;
                        w_skid_data_nxt = BUBBLE;
                    end
                end
                default: begin
                    w_state_nxt     = EMPTY;
                    w_main_data_nxt = BUBBLE;
                    w_skid_data_nxt = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= EMPTY;
            r_main_data <= BUBBLE;
            r_skid_data <= BUBBLE;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_data_nxt;
            r_skid_data <= w_skid_data_nxt;
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic w_stall_inc;
    logic w_flush_inc;

    // A held-back valid entry: downstream not ready, or the stage is frozen.
    assign w_stall_inc = w_main_valid & (~out_ready | freeze);
    // A skid entry implies a main entry, so main_valid covers "any valid entry".
    assign w_flush_inc = flush & w_main_valid;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_stall_inc),
        .o_count (stall_cnt)
    );

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_flush_inc),
        .o_count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. The reference model treats the stage
// as a FIFO of capacity two: ready while fewer than two entries are held, the
// head is presented downstream, freeze blocks both sides and flush empties it.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 64;
    localparam logic [63:0] BUBBLE = 64'h0;
`ifdef PIPE_STAGE_PERF_CNT_EN
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;
`else
    localparam int          CNT_MAX = 65535;
`endif

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic              freeze    = 1'b0;
    logic              flush     = 1'b0;
    logic              in_valid  = 1'b0;
    logic [DATA_W-1:0] in_data   = '0;
    logic              out_ready = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .BUBBLE (BUBBLE)
`ifdef PIPE_STAGE_PERF_CNT_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef PIPE_STAGE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [DATA_W-1:0] q[$];
    int stall_m = 0;
    int flush_m = 0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs just after a rising edge, compare outputs
    // at the falling edge, then advance the model across the next rising edge.
    task automatic step(input string tag, input logic fz, input logic fl, input logic iv,
                        input logic [DATA_W-1:0] d, input logic ordy);
        logic              exp_ir;
        logic              exp_ov;
        logic [DATA_W-1:0] exp_od;
        freeze    = fz;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        exp_ir = (q.size() < 2) && !fz;
        exp_ov = (q.size() > 0) && !fz;
        exp_od = (q.size() > 0) ? q[0] : BUBBLE;
        chk_bit({tag, ".in_ready"}, in_ready, exp_ir);
        chk_bit({tag, ".out_valid"}, out_valid, exp_ov);
        chk_data({tag, ".out_data"}, out_data, exp_od);
`ifdef PIPE_STAGE_PERF_CNT_EN
        chk_cnt({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(stall_m));
        chk_cnt({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(flush_m));
`endif
        if ((q.size() > 0) && (!ordy || fz) && stall_m < CNT_MAX) stall_m++;
        if (fl) begin
            if (q.size() > 0 && flush_m < CNT_MAX) flush_m++;
            q.delete();
        end else if (!fz) begin
            if (exp_ov && ordy) void'(q.pop_front());
            if (iv && exp_ir) q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] pa;
        logic [DATA_W-1:0] pb;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pd;
        pa = 64'h1000_0000_E3A0_0001;
        pb = 64'h1000_0004_E3A0_0002;
        pc = 64'h1000_0008_E3A0_0003;
        pd = 64'hDEAD_BEEF_0BAD_F00D;

        // Reset held for two cycles, outputs checked while still in reset.
        repeat (2) @(posedge clk);
        #1;
        chk_bit("rst.in_ready", in_ready, 1'b1);
        chk_bit("rst.out_valid", out_valid, 1'b0);
        chk_data("rst.out_data", out_data, BUBBLE);
        rst = 1'b1;
        step("idle", 0, 0, 0, '0, 1);

        // Streaming: back-to-back, one cycle latency, no gaps.
        step("str0", 0, 0, 1, pa, 1);
        step("str1", 0, 0, 1, pb, 1);
        step("str2", 0, 0, 0, '0, 1);
        step("str3", 0, 0, 0, '0, 1);

        // Skid fill: A, B held; C stalls while in_ready is low.
        step("skA", 0, 0, 1, pa, 0);
        step("skB", 0, 0, 1, pb, 0);
        step("skC0", 0, 0, 1, pc, 0);
        step("skC1", 0, 0, 1, pc, 0);
        step("skD0", 0, 0, 1, pc, 1);
        step("skD1", 0, 0, 1, pc, 1);
        step("skD2", 0, 0, 0, '0, 1);
        step("skD3", 0, 0, 0, '0, 1);

        // Freeze in TWO with both handshakes offered.
        step("fzA", 0, 0, 1, pa, 0);
        step("fzB", 0, 0, 1, pb, 0);
        for (int i = 0; i < 3; i++) step("fz", 1, 0, 1, pd, 1);
        step("fzR0", 0, 0, 0, '0, 1);
        step("fzR1", 0, 0, 0, '0, 1);
        step("fzR2", 0, 0, 0, '0, 1);

        // Flush in TWO together with freeze and a valid input.
        step("flA", 0, 0, 1, pa, 0);
        step("flB", 0, 0, 1, pb, 0);
        step("fl", 1, 1, 1, pd, 1);
        step("flE0", 0, 0, 0, '0, 1);
        step("flE1", 0, 0, 0, '0, 1);
`ifdef PIPE_STAGE_PERF_CNT_EN
        chk_cnt("flush_cnt_one", 32'(flush_cnt), 32'd1);
`endif

        // Long downstream stall: stall counter saturates and holds.
        step("satA", 0, 0, 1, pa, 0);
        for (int i = 0; i < 20; i++) step("sat", 0, 0, 0, '0, 0);
`ifdef PIPE_STAGE_PERF_CNT_EN
        chk_cnt("stall_sat", 32'(stall_cnt), 32'd15);
`endif
        step("satD", 0, 0, 0, '0, 1);

        // Asynchronous reset in the middle of a transfer: nothing retained.
        step("arA", 0, 0, 1, pa, 0);
        step("arB", 0, 0, 1, pb, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_bit("arst.in_ready", in_ready, 1'b1);
        chk_bit("arst.out_valid", out_valid, 1'b0);
        chk_data("arst.out_data", out_data, BUBBLE);
        q.delete();
        stall_m = 0;
        flush_m = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("arE", 0, 0, 0, '0, 1);

        // Randomised traffic against the FIFO model.
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 7) == 0), ($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 1)), {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic successor to the fixed IF/ID pipeline register.
- Carries an opaque DATA_W-bit payload (e.g. {PC, Instruction}) between any two ARM pipeline stages.
- Uses a valid/ready handshake and a 2-entry skid buffer so the upstream `ready` is registered.
- Keeps the existing freeze (stall) and flush (bubble insert) semantics; the bubble value is parametrised.

Parameters:
- DATA_W, 64, payload width in bits.
- BUBBLE, {DATA_W{1'b0}}, payload driven and held when no valid entry is present or after flush.
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- freeze  in  1  stall: no transfer on either side this cycle
- flush  in  1  synchronous kill of all held and incoming entries
- in_valid  in  1  upstream payload valid
- in_data  in  DATA_W  upstream payload
- in_ready  out  1  stage can accept (registered, skid-free)
- out_valid  out  1  downstream payload valid
- out_data  out  DATA_W  downstream payload
- out_ready  in  1  downstream accepts

Behaviour:
- Reset (rst=0, async):
  - State EMPTY; main and skid entries invalid; both data registers = BUBBLE.
  - Outputs: in_ready=1, out_valid=0, out_data=BUBBLE.
- Transfers:
  - Accept: in_valid & in_ready & ~freeze.
  - Issue: out_valid & out_ready (out_valid is already 0 under freeze).
- Combinational masking:
  - out_valid = main_valid & ~freeze.
  - out_data = main_data, held during freeze.
  - in_ready = ~skid_valid & ~freeze.
- States (main/skid valid):
  - EMPTY: accept -> ONE, data to main.
  - ONE:
    - accept & issue -> ONE, main replaced.
    - accept & ~issue -> TWO, data to skid.
    - ~accept & issue -> EMPTY, main := BUBBLE.
    - otherwise hold.
  - TWO (in_ready=0):
    - issue -> ONE, skid moves to main, skid := BUBBLE.
    - otherwise hold.
- Ordering: FIFO order always preserved. Latency is 1 cycle from accept to out_valid when EMPTY/ONE; zero throughput loss on a single-cycle downstream stall.
- Freeze: all registers hold their value; no accept, no issue.
- Flush:
  - Synchronous, priority over freeze and all handshakes.
  - Next state EMPTY; both entries := BUBBLE.
  - An input presented in the flush cycle is dropped, even if in_valid=1.
  - in_ready returns to 1 the next cycle unless freeze is asserted.
- Reset mid-transfer: the entry is lost; nothing is retained.
- Invalid entries always hold BUBBLE, so downstream decode sees a NOP.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- When defined:
  - Adds output ports stall_cnt (CNT_W) and flush_cnt (CNT_W).
  - stall_cnt increments each cycle with out_valid_pre (main_valid) & (~out_ready | freeze).
  - flush_cnt increments per flush cycle that kills at least one valid entry.
  - Both counters saturate at all-ones and are cleared by rst.
- When undefined: ports and logic are absent, and the module is bit-identical in behaviour otherwise.

Decomposition:
- Package pipe_pkg holds:
  - State enum (EMPTY=2'd0, ONE=2'd1, TWO=2'd2).
  - Default DATA_W constants for the IF/ID (64) and ID/EX payloads.
  - ARM NOP bubble constant.
- Optional sub-module: pipe_sat_counter (CNT_W saturating counter), instantiated twice under the macro.

Test Plan:
- Reset/EMPTY:
  - Stimulus: rst=0 for 2 cycles, release, in_valid=0.
  - Required: in_ready=1, out_valid=0, out_data=BUBBLE (64'h0).
- Streaming:
  - Stimulus: out_ready=1; push 0x1000_0000_E3A0_0001, 0x1000_0004_E3A0_0002 back-to-back.
  - Required: each appears on out_data 1 cycle after accept, no gaps.
- Skid:
  - Stimulus: fill A, B, C with out_ready=0.
  - Required: A and B held; in_ready=0 after B; C stalls.
  - Then out_ready=1: A, B, C issued in order, in_ready=1 after A drains.
- Freeze:
  - Stimulus: state TWO, freeze=1 for 3 cycles with out_ready=1, in_valid=1.
  - Required: out_valid=0, in_ready=0, contents unchanged; release resumes with the same data.
- Flush:
  - Stimulus: state TWO, flush=1 together with freeze=1 and in_valid=1.
  - Required: next cycle EMPTY, out_data=BUBBLE, the incoming payload never appears; with the macro, flush_cnt=1.
- Saturation (macro, CNT_W=4):
  - Stimulus: 20 stall cycles.
  - Required: stall_cnt=4'hF and holds.
